systolic_feeder: RTL and testbench

// - Operand transmitter for the 4x4 systolic multiplier array (lanes left_*, up_*, done).
// - Stores a 4x4 matrix A and a 4x4 matrix B via a word-write port.
// - On start, streams A rows into the left edge and B columns into the top edge, skewed one cycle per lane.
// - Then waits for the array's done, with timeout.

---
 rtl/systolic_feeder.sv | 173 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: operand transmitter for a 4x4 systolic multiplier array.
// Holds matrices A and B, which are loaded through a word-write port.
// On start the block clears the array, then streams skewed A rows into the
// left edge and skewed B columns into the top edge. It then waits for the
// array's done, or aborts on timeout.
// Optional feature: define FEED_PERF_CNT_EN to add a cycles_o [15:0]
// performance counter.
module systolic_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  wr_sel_i,
    input  logic [3:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  start_i,
    input  logic                  done_i,
    output logic                  arr_rst_no,
    output logic [DATA_WIDTH-1:0] left_o_0,
    output logic [DATA_WIDTH-1:0] left_o_4,
    output logic [DATA_WIDTH-1:0] left_o_8,
    output logic [DATA_WIDTH-1:0] left_o_12,
    output logic [DATA_WIDTH-1:0] up_o_0,
    output logic [DATA_WIDTH-1:0] up_o_1,
    output logic [DATA_WIDTH-1:0] up_o_2,
    output logic [DATA_WIDTH-1:0] up_o_3,
    output logic                  busy_o,
    output logic                  done_o,
`ifdef FEED_PERF_CNT_EN
    output logic [15:0]           cycles_o,
`endif
    output logic                  err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_WAIT, S_DONE} state_t;

    state_t                          r_state, w_state_nxt;
    logic [2:0]                      r_t, w_t_nxt;
    logic [CW-1:0]                   r_to_cnt;
    logic                            w_timeout;
    logic [15:0][DATA_WIDTH-1:0]     r_a, r_b;
    logic [3:0][DATA_WIDTH-1:0]      w_left, w_up;

    // Next-state and feed-step sequencing
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: if (start_i) w_state_nxt = S_CLR;
            S_CLR: begin
                w_state_nxt = S_FEED;
                w_t_nxt     = 3'd0;
            end
            S_FEED: begin
                if (r_t == 3'd6) begin
                    w_state_nxt = S_WAIT;
                    w_t_nxt     = 3'd0;
                end else begin
                    w_t_nxt = r_t + 3'd1;
                end
            end
            S_WAIT: begin
                if (done_i) begin
                    w_state_nxt = S_DONE;
                end else if (r_to_cnt == CW'(TIMEOUT)) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lane values for the upcoming step; outputs are registered from these
    // values, so the lanes change on the same edge as the state.
    always_comb begin
        w_left = '0;
        w_up   = '0;
        if (w_state_nxt == S_FEED) begin
            for (int i = 0; i < 4; i++) begin
                if ((int'(w_t_nxt) - i) >= 0 && (int'(w_t_nxt) - i) <= 3) begin
                    w_left[i] = r_a[4'(i * 4 + int'(w_t_nxt) - i)];
                    w_up[i]   = r_b[4'((int'(w_t_nxt) - i) * 4 + i)];
                end
            end
        end
    end

    // State register, step counter and the wait-done timeout counter.
    // The counter is held at zero outside WAIT_DONE and saturates at TIMEOUT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_t      <= 3'd0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            if (r_state != S_WAIT)
                r_to_cnt <= '0;
            else if (r_to_cnt != CW'(TIMEOUT))
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Matrix storage, writable only while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a <= '0;
            r_b <= '0;
        end else if (r_state == S_IDLE && wr_en_i) begin
            if (wr_sel_i) r_b[wr_addr_i] <= wr_data_i;
            else          r_a[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered outputs derived from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            left_o_0   <= '0;
            left_o_4   <= '0;
            left_o_8   <= '0;
            left_o_12  <= '0;
            up_o_0     <= '0;
            up_o_1     <= '0;
            up_o_2     <= '0;
            up_o_3     <= '0;
            arr_rst_no <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            left_o_0   <= w_left[0];
            left_o_4   <= w_left[1];
            left_o_8   <= w_left[2];
            left_o_12  <= w_left[3];
            up_o_0     <= w_up[0];
            up_o_1     <= w_up[1];
            up_o_2     <= w_up[2];
            up_o_3     <= w_up[3];
            arr_rst_no <= (w_state_nxt != S_CLR);
            busy_o     <= (w_state_nxt != S_IDLE);
            done_o     <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_CLR) err_o <= 1'b0;
            else if (w_timeout)       err_o <= 1'b1;
        end
    end

`ifdef FEED_PERF_CNT_EN
    logic [15:0] r_cycles;

    // Count cycles spent in CLR/FEED/WAIT_DONE since start acceptance.
    // The counter saturates, and holds its value once the run is done.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_cycles <= '0;
        else if (r_state == S_IDLE && start_i)
            r_cycles <= '0;
        else if ((r_state == S_CLR || r_state == S_FEED || r_state == S_WAIT)
                 && r_cycles != 16'hFFFF)
            r_cycles <= r_cycles + 16'd1;
    end

    assign cycles_o = r_cycles;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder.
// It runs the spec load pattern and checks the skewed lanes, the array
// product, the done path, the timeout path, ignored writes/starts and a
// mid-feed reset.
module tb_systolic_feeder;

    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk_i = 1'b0;
    logic          rst_i, wr_en_i, wr_sel_i, start_i, done_i;
    logic [3:0]    wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          arr_rst_no, busy_o, done_o, err_o;
    logic [DW-1:0] left_o_0, left_o_4, left_o_8, left_o_12;
    logic [DW-1:0] up_o_0, up_o_1, up_o_2, up_o_3;
`ifdef FEED_PERF_CNT_EN
    logic [15:0]   cycles_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    longint lft [4][7];
    longint upv [4][7];

    systolic_feeder #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .start_i(start_i),
        .done_i(done_i), .arr_rst_no(arr_rst_no),
        .left_o_0(left_o_0), .left_o_4(left_o_4), .left_o_8(left_o_8),
        .left_o_12(left_o_12), .up_o_0(up_o_0), .up_o_1(up_o_1),
        .up_o_2(up_o_2), .up_o_3(up_o_3), .busy_o(busy_o), .done_o(done_o),
`ifdef FEED_PERF_CNT_EN
        .cycles_o(cycles_o),
`endif
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic capture(input int t);
        lft[0][t] = left_o_0; lft[1][t] = left_o_4;
        lft[2][t] = left_o_8; lft[3][t] = left_o_12;
        upv[0][t] = up_o_0;   upv[1][t] = up_o_1;
        upv[2][t] = up_o_2;   upv[3][t] = up_o_3;
    endtask

    initial begin
        int n;
        longint acc;
        logic [31:0] c_exp [4];
        rst_i = 1'b1; wr_en_i = 1'b0; wr_sel_i = 1'b0; wr_addr_i = '0;
        wr_data_i = '0; start_i = 1'b0; done_i = 1'b0;
        tick; tick;
        rst_i = 1'b0;
        tick;
        chk("rst_busy", busy_o, 0);
        chk("rst_arr_rst_no", arr_rst_no, 1);
        chk("rst_left0", left_o_0, 0);
        chk("rst_up3", up_o_3, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);

        // Load A = 1..16 row-major, B[k][c] = c+1
        for (int i = 0; i < 32; i++) begin
            wr_en_i   = 1'b1;
            wr_sel_i  = (i >= 16);
            wr_addr_i = 4'(i % 16);
            wr_data_i = (i < 16) ? 32'(i + 1) : 32'((i % 4) + 1);
            tick;
        end
        wr_en_i = 1'b0;

        // Run 1: normal run. A write and a start are attempted mid-feed.
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("clr_arr_rst_no", arr_rst_no, 0);
        chk("clr_busy", busy_o, 1);
        chk("clr_left0", left_o_0, 0);
        for (int t = 0; t < 7; t++) begin
            tick;
            capture(t);
            chk("feed_arr_rst_no", arr_rst_no, 1);
            if (t == 0) begin
                chk("t0_left0", left_o_0, 1);
                chk("t0_up0", up_o_0, 1);
                chk("t0_left4", left_o_4, 0);
                chk("t0_up1", up_o_1, 0);
            end
            if (t == 1) begin
                wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_addr_i = 4'd0;
                wr_data_i = 32'd99; start_i = 1'b1;
            end
            if (t == 2) begin
                wr_en_i = 1'b0; start_i = 1'b0;
            end
            if (t == 3) begin
                chk("t3_left0", left_o_0, 4);
                chk("t3_left4", left_o_4, 7);
                chk("t3_left12", left_o_12, 13);
                chk("t3_up3", up_o_3, 4);
            end
            if (t == 6) begin
                chk("t6_left12", left_o_12, 16);
                chk("t6_up3", up_o_3, 4);
                chk("t6_left0", left_o_0, 0);
                chk("t6_left8", left_o_8, 0);
                chk("t6_up2", up_o_2, 0);
            end
        end
        tick;
        chk("wait_left12", left_o_12, 0);
        chk("wait_done_low", done_o, 0);
        chk("wait_busy", busy_o, 1);
        done_i = 1'b1;
        tick;
        chk("run1_done_pulse", done_o, 1);
        chk("run1_err", err_o, 0);
        done_i = 1'b0;
        tick;
        chk("run1_done_clear", done_o, 0);
        chk("run1_idle", busy_o, 0);

        // Array product recovered from the captured skewed lanes
        c_exp[0] = 10; c_exp[1] = 20; c_exp[2] = 30; c_exp[3] = 40;
        for (int r = 0; r < 4; r += 3) begin
            for (int c = 0; c < 4; c++) begin
                acc = 0;
                for (int tau = 0; tau < 13; tau++)
                    if (tau - c >= 0 && tau - c < 7 && tau - r >= 0 && tau - r < 7)
                        acc += lft[r][tau - c] * upv[c][tau - r];
                chk($sformatf("C%0d%0d", r, c), 32'(acc),
                    (r == 0) ? c_exp[c] : 32'(58 * (c + 1)));
            end
        end

        // Run 2: done_i held high throughout; must not cut the feed short
        done_i  = 1'b1;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("run2_clr_done", done_o, 0);
        tick;
        chk("run2_t0_left0_unchanged", left_o_0, 1);
        chk("run2_t0_done", done_o, 0);
        for (int t = 1; t < 7; t++) tick;
        chk("run2_t6_left12", left_o_12, 16);
        tick;
        chk("run2_wait_done_low", done_o, 0);
        tick;
        chk("run2_done_pulse", done_o, 1);
`ifdef FEED_PERF_CNT_EN
        chk("run2_cycles", cycles_o, 9);
`endif
        done_i = 1'b0;
        tick;
        chk("run2_idle", busy_o, 0);
`ifdef FEED_PERF_CNT_EN
        chk("run2_cycles_hold", cycles_o, 9);
`endif

        // Run 3: timeout
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        for (int t = 0; t < 7; t++) tick;
        tick;
        chk("run3_in_wait", busy_o, 1);
        n = 0;
        for (int k = 1; k <= TO + 10; k++) begin
            tick;
            if (done_o) begin
                n = k;
                break;
            end
        end
        chk("timeout_latency", n, TO + 1);
        chk("timeout_err", err_o, 1);
        tick;
        chk("timeout_err_sticky", err_o, 1);
        chk("timeout_idle", busy_o, 0);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("err_cleared_on_start", err_o, 0);

        // Run 4: reset during FEED t=2
        tick; tick; tick;
        chk("run4_t2_left0", left_o_0, 3);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_left0", left_o_0, 0);
        chk("midrst_up0", up_o_0, 0);
        chk("midrst_arr_rst_no", arr_rst_no, 1);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done_o) n++;
        end
        chk("midrst_no_done", n, 0);

        // Storage cleared: a new run streams zeros
        done_i  = 1'b1;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        for (int t = 0; t < 4; t++) tick;
        chk("cleared_t3_left0", left_o_0, 0);
        chk("cleared_t3_left12", left_o_12, 0);
        chk("cleared_t3_up3", up_o_3, 0);
        chk("cleared_t3_busy", busy_o, 1);
        for (int t = 4; t < 7; t++) tick;
        tick; tick;
        chk("run5_done_pulse", done_o, 1);
        done_i = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
